// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16550-style receive FIFO with per-character error flags, overrun, trigger and character timeout
module uart_rx_fifo #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic [2:0]               rx_err,
  input  logic                     div_clk_en,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [2:0]               rd_err,
  output logic                     data_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     fifo_err,
  output logic                     overrun,
  input  logic                     overrun_clr,
  input  logic                     cfg_fifo_en,
  input  logic                     cfg_fifo_rst,
  input  logic [1:0]               cfg_trigger,
  output logic                     trigger_hit,
  output logic                     timeout
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int TOW = $clog2(TIMEOUT_TICKS + 1);
  localparam int TW  = (CW > 5) ? CW : 5;
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, r_err_cnt;
  logic [TOW-1:0] r_to_cnt;
  logic          r_ovr, r_fifo_en_q;
  logic [10:0]   w_head;
  logic [CW-1:0] w_cap;
  logic [4:0]    w_trig_lvl;
  logic          w_flush, w_empty, w_full, w_rd, w_wr, w_ovw, w_ovr_set, w_inc, w_dec;
  always_comb begin
    w_head     = r_mem[r_rp];
    w_flush    = cfg_fifo_rst | (cfg_fifo_en ^ r_fifo_en_q);
    w_cap      = cfg_fifo_en ? CW'(DEPTH) : CW'(1);
    w_empty    = (r_cnt == '0);
    w_full     = (r_cnt >= w_cap);
    w_rd       = rd_en & ~w_empty & ~w_flush;
    w_wr       = rx_valid & (~w_full | w_rd) & ~w_flush;
    w_ovr_set  = rx_valid & w_full & ~w_rd & ~w_flush;
    // holding-register mode replaces the single entry in place
    w_ovw      = w_ovr_set & ~cfg_fifo_en;
    w_inc      = (w_wr | w_ovw) & (|rx_err);
    w_dec      = (w_rd | w_ovw) & (|w_head[10:8]);
    w_trig_lvl = (cfg_trigger == 2'd0) ? 5'd1 :
                 (cfg_trigger == 2'd1) ? 5'd4 :
                 (cfg_trigger == 2'd2) ? 5'd8 : 5'd14;
  end
  always_ff @(posedge clk) begin
    if (w_wr | w_ovw) r_mem[w_ovw ? r_rp : r_wp] <= {rx_err, rx_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_err_cnt   <= '0;
      r_ovr       <= 1'b0;
      r_fifo_en_q <= 1'b0;
    end else begin
      r_fifo_en_q <= cfg_fifo_en;
      r_ovr       <= w_ovr_set | (r_ovr & ~overrun_clr);
      if (w_flush) begin
        r_wp      <= '0;
        r_rp      <= '0;
        r_cnt     <= '0;
        r_err_cnt <= '0;
      end else begin
        if (w_wr) r_wp <= r_wp + AW'(1);
        if (w_rd) r_rp <= r_rp + AW'(1);
        r_cnt     <= r_cnt + CW'(w_wr) - CW'(w_rd);
        r_err_cnt <= r_err_cnt + CW'(w_inc) - CW'(w_dec);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_to_cnt <= '0;
    else if (w_flush | rx_valid | rd_en | w_empty) r_to_cnt <= '0;
    else if (div_clk_en && r_to_cnt != TOW'(TIMEOUT_TICKS)) r_to_cnt <= r_to_cnt + TOW'(1);
  end
  assign rd_data     = w_empty ? 8'h00 : w_head[7:0];
  assign rd_err      = w_empty ? 3'b000 : w_head[10:8];
  assign data_ready  = ~w_empty;
  assign count       = r_cnt;
  assign fifo_err    = (r_err_cnt != '0);
  assign overrun     = r_ovr;
  assign trigger_hit = cfg_fifo_en ? (TW'(r_cnt) >= TW'(w_trig_lvl)) : ~w_empty;
  assign timeout     = cfg_fifo_en & (r_to_cnt == TOW'(TIMEOUT_TICKS));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard-driven self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [2:0] rx_err = '0;
  logic       div_clk_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic [2:0] rd_err;
  logic       data_ready;
  logic [4:0] count;
  logic       fifo_err;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       cfg_fifo_en = 1'b1;
  logic       cfg_fifo_rst = 1'b0;
  logic [1:0] cfg_trigger = 2'd0;
  logic       trigger_hit;
  logic       timeout;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [10:0] sbq[$];
  always #5 clk = ~clk;
  uart_rx_fifo #(.DEPTH(16), .TIMEOUT_TICKS(640)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .div_clk_en(div_clk_en), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .data_ready(data_ready), .count(count), .fifo_err(fifo_err), .overrun(overrun),
    .overrun_clr(overrun_clr), .cfg_fifo_en(cfg_fifo_en), .cfg_fifo_rst(cfg_fifo_rst),
    .cfg_trigger(cfg_trigger), .trigger_hit(trigger_hit), .timeout(timeout)
  );
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic [2:0] e, input bit accept);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_err   = e;
    if (accept) sbq.push_back({e, d});
    tick();
    rx_valid = 1'b0;
    rx_err   = '0;
  endtask
  task automatic pop(input string tag);
    logic [10:0] exp;
    exp = (sbq.size() != 0) ? sbq.pop_front() : 11'h000;
    check(tag, {21'd0, rd_err, rd_data}, {21'd0, exp});
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask
  initial begin
    logic [10:0] tmp;
    #3;
    check("rst_count", count, 0);
    check("rst_dr", data_ready, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ovr", overrun, 0);
    check("rst_ferr", fifo_err, 0);
    check("rst_to", timeout, 0);
    check("rst_trig", trigger_hit, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    send(8'h41, 3'b000, 1'b1);
    send(8'h42, 3'b000, 1'b1);
    send(8'h43, 3'b000, 1'b1);
    check("t1_count", count, 3);
    check("t1_dr", data_ready, 1);
    check("t1_head", rd_data, 8'h41);
    for (int i = 0; i < 3; i++) pop("t1_pop");
    check("t1_count_end", count, 0);
    check("t1_rd_empty", rd_data, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("empty_rd_count", count, 0);
    for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 3'b000, 1'b1);
    send(8'h99, 3'b000, 1'b0);
    check("t2_ovr", overrun, 1);
    check("t2_count", count, 16);
    check("t2_trig", trigger_hit, 1);
    for (int i = 0; i < 16; i++) pop("t2_pop");
    check("t2_count_end", count, 0);
    check("t2_ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t2_ovr_clr", overrun, 0);
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 3'b000, 1'b1);
    tmp = sbq.pop_front();
    check("t3_head", rd_data, {24'd0, tmp[7:0]});
    sbq.push_back({3'b000, 8'h77});
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    rd_en    = 1'b1;
    tick();
    rx_valid = 1'b0;
    rd_en    = 1'b0;
    check("t3_count", count, 16);
    check("t3_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) pop("t3_pop");
    check("t3_count_end", count, 0);
    send(8'h01, 3'b000, 1'b1);
    send(8'h02, 3'b100, 1'b1);
    send(8'h03, 3'b000, 1'b1);
    check("t4_ferr0", fifo_err, 1);
    pop("t4_pop");
    check("t4_ferr1", fifo_err, 1);
    pop("t4_pop");
    check("t4_ferr2", fifo_err, 0);
    pop("t4_pop");
    cfg_trigger = 2'd2;
    for (int i = 0; i < 7; i++) send(8'hC0 + 8'(i), 3'b010, 1'b1);
    check("t5_trig7", trigger_hit, 0);
    send(8'hC7, 3'b000, 1'b1);
    check("t5_trig8", trigger_hit, 1);
    cfg_fifo_rst = 1'b1;
    tick();
    cfg_fifo_rst = 1'b0;
    sbq.delete();
    check("flush_count", count, 0);
    check("flush_ferr", fifo_err, 0);
    check("flush_dr", data_ready, 0);
    cfg_trigger = 2'd0;
    send(8'h55, 3'b000, 1'b1);
    div_clk_en = 1'b1;
    for (int i = 0; i < 639; i++) tick();
    check("t6_to_early", timeout, 0);
    tick();
    div_clk_en = 1'b0;
    check("t6_to", timeout, 1);
    pop("t6_pop");
    check("t6_to_clr", timeout, 0);
    check("t6_count", count, 0);
    cfg_fifo_en = 1'b0;
    tick();
    tick();
    send(8'h11, 3'b000, 1'b1);
    check("t7_ovr0", overrun, 0);
    void'(sbq.pop_back());
    send(8'h22, 3'b000, 1'b1);
    check("t7_data", rd_data, 8'h22);
    check("t7_ovr", overrun, 1);
    check("t7_count", count, 1);
    check("t7_trig", trigger_hit, 1);
    check("t7_to", timeout, 0);
    pop("t7_pop");
    check("t7_count_end", count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
